// File: rtl/truncate_clusters_multi.sv
// Multi-lane successor cluster truncator.
// Latches a VPF vector, then on each following clock clears the NLANES
// lowest-index set bits (globally ordered across segments) for up to
// MXPASSES passes, reporting empty/busy status and a sticky overflow flag.
module truncate_clusters_multi #(
   parameter int MXVPF    = 1536,
   parameter int MXSEGS   = 16,
   parameter int NLANES   = 1,
   parameter int MXPASSES = 8,
   parameter int PASSB    = $clog2(MXPASSES+1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             latch_pulse,
   input  logic [MXVPF-1:0] vpfs_in,
   output logic [MXVPF-1:0] vpfs_out,
   output logic [PASSB-1:0] pass_o,
   output logic             empty_o,
   output logic             busy_o,
   output logic             overflow_o
);

   localparam int SEGSIZE = MXVPF / MXSEGS;
   localparam logic [PASSB-1:0] PASS_MAX  = PASSB'(MXPASSES);
   localparam logic [PASSB-1:0] PASS_LAST = PASSB'(MXPASSES - 1);

   if (MXVPF % MXSEGS != 0) begin : g_bad_segs
      $error("MXVPF must be divisible by MXSEGS");
   end
   if (NLANES < 1 || NLANES > 4) begin : g_bad_lanes
      $error("NLANES must be in 1..4");
   end
   if (MXPASSES < 1) begin : g_bad_passes
      $error("MXPASSES must be at least 1");
   end

   logic [MXVPF-1:0] ff_q, ff_d, next_ff;
   logic [PASSB-1:0] pass_q, pass_d;
   logic             ovf_q, ovf_d;

   // Clear the lowest set bit of the lowest non-empty segment. Each segment
   // subtracts only within its own SEGSIZE bits, so no borrow crosses a
   // boundary; segments above the first non-empty one pass through unchanged.
   function automatic logic [MXVPF-1:0] drop_lowest(input logic [MXVPF-1:0] v);
      logic [MXVPF-1:0]   r;
      logic [SEGSIZE-1:0] seg;
      logic               found;
      r     = v;
      found = 1'b0;
      for (int unsigned s = 0; s < MXSEGS; s++) begin
         seg = v[s*SEGSIZE +: SEGSIZE];
         if (!found) r[s*SEGSIZE +: SEGSIZE] = seg & ~(-seg);
         found = found | (|seg);
      end
      return r;
   endfunction

   // Cascade NLANES single-bit removals combinationally
   always_comb begin
      next_ff = ff_q;
      for (int unsigned l = 0; l < NLANES; l++) begin
         next_ff = drop_lowest(next_ff);
      end
   end

   // Next-state: latch has priority, otherwise advance until the pass limit
   always_comb begin
      ff_d   = ff_q;
      pass_d = pass_q;
      ovf_d  = ovf_q;
      if (latch_pulse) begin
         ff_d   = vpfs_in;
         pass_d = '0;
         ovf_d  = 1'b0;
      end else if (pass_q < PASS_MAX) begin
         ff_d   = next_ff;
         pass_d = pass_q + 1'b1;
         ovf_d  = (pass_q == PASS_LAST) && (|next_ff);
      end
   end

   // State registers with asynchronous reset to the idle/frozen state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ff_q   <= '0;
         pass_q <= PASS_MAX;
         ovf_q  <= 1'b0;
      end else begin
         ff_q   <= ff_d;
         pass_q <= pass_d;
         ovf_q  <= ovf_d;
      end
   end

   // Outputs and combinational status
   always_comb begin
      vpfs_out   = ff_q;
      pass_o     = pass_q;
      overflow_o = ovf_q;
      empty_o    = ~|ff_q;
      busy_o     = (|ff_q) && (pass_q < PASS_MAX);
   end

endmodule

// File: doc/truncate_clusters_multi.md
# truncate_clusters_multi

Parametrised successor cluster truncator for the S-bit cluster-finding path. It latches a wide VPF vector once per BX and, on every following clock, clears the NLANES lowest-index set bits, globally ordered across all segments. The downstream priority encoders derive cluster positions from the successive vpfs_out snapshots. Unlike the single-lane version, it:

- stops after a programmable number of passes,
- reports empty and busy status,
- flags overflow when clusters remain after the last pass.

## Interface
- MXVPF, 1536: width of VPF vector; must be divisible by MXSEGS (elaboration error otherwise).
- MXSEGS, 16: number of segments; SEGSIZE = MXVPF/MXSEGS.
- NLANES, 1: bits cleared per clock, 1..4; lanes are cascaded combinationally.
- MXPASSES, 8: truncation passes per latch, >= 1.
- PASSB, $clog2(MXPASSES+1): pass counter width.

Ports:
- clock  in  1  logic clock (160 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- latch_pulse  in  1  load vpfs_in and restart pass count.
- vpfs_in  in  MXVPF  incoming VPF vector.
- vpfs_out  out  MXVPF  current truncated vector (registered).
- pass_o  out  PASSB  passes completed since latch; saturates at MXPASSES.
- empty_o  out  1  vpfs_out == 0.
- busy_o  out  1  !empty_o && pass_o < MXPASSES.
- overflow_o  out  1  sticky: bits remained when pass_o reached MXPASSES.

## Operation
Reset values: vpfs_out = 0, pass_o = MXPASSES, empty_o = 1, busy_o = 0, overflow_o = 0.

Per-clock register update:
- **latch_pulse = 1** (highest priority; aborts any pass in progress): ff <= vpfs_in, pass_o <= 0, overflow_o <= 0.
- **else if pass_o < MXPASSES**:
  - ff <= next_ff, where next_ff applies NLANES successive single-bit removals to ff.
  - pass_o <= pass_o + 1.
  - overflow_o <= (pass_o == MXPASSES-1) && (|next_ff).
- **else (pass_o == MXPASSES)**: ff, pass_o and overflow_o hold (frozen).

Single-bit removal on a vector v:
- Clears only the lowest set bit in the lowest active segment, using seg & ~(-seg).
- Every segment with any active lower-index segment is passed unchanged (per-segment keep).
- v == 0 stays 0.
- Width of each subtraction is SEGSIZE; no carry crosses a segment boundary.

Status outputs:
- empty_o and busy_o are combinational from ff and pass_o.
- After the last set bit is removed, remaining passes run with ff = 0; pass_o keeps counting to MXPASSES.

## Timing
- latch_pulse at edge N: vpfs_out = vpfs_in and pass_o = 0 after edge N.
- After edge N+p (p <= MXPASSES, no further latch), vpfs_out has lost its min(p·NLANES, popcount) lowest set bits, and pass_o = p.
- overflow_o rises after edge N+MXPASSES, together with pass_o = MXPASSES. It stays high until the next latch_pulse or reset.
- Consecutive latch_pulses every cycle: each edge reloads and no truncation occurs; pass_o stays 0.
- Asynchronous reset mid-pass: outputs go to reset values immediately. The first latch_pulse after deassertion restarts normally.
- Critical path is NLANES × (segment subtract + keep chain). NLANES > 2 is not guaranteed to close at 160 MHz.

## Test plan
Bench parameters: MXVPF=64, MXSEGS=4, MXPASSES=8, NLANES=1 unless noted.

1. **Reset.** Assert reset with random vpfs_in -> vpfs_out = 0, pass_o = 8, empty_o = 1, busy_o = 0, overflow_o = 0. Deassert with no latch -> outputs hold.
2. **Basic truncation.** Latch bits {3,17,40} -> vpfs_out sequence:
   - pass 0: {3,17,40}
   - pass 1: {17,40}
   - pass 2: {40}
   - pass 3: {} with empty_o = 1 and busy_o = 0
   - pass_o reaches 8; overflow_o = 0.
3. **Segment boundary, NLANES=2.** Latch bits {0,1,15,16,63}:
   - pass 1: {15,16,63}
   - pass 2: {63}
   - pass 3: {}
4. **Overflow.** Latch bits 0..9 -> at pass 8, vpfs_out = {8,9}, overflow_o = 1. Values stay frozen for 5 more clocks; next latch_pulse clears overflow_o.
5. **Abort.** latch_pulse with {5,6,7}, then at pass 1 latch_pulse with {60} -> pass_o = 0, vpfs_out = {60}, then {} at pass 1.
6. **Full vector.** Latch all 64 bits set -> at pass 8, vpfs_out = bits 8..63 and overflow_o = 1. Async reset asserted mid-pass 4 -> immediate reset values.
